gcd_client: RTL and testbench
=============================

# gcd_client

Request-side sequencer for the GCD engine, which exposes in1/in2/go inputs and out/done outputs. It accepts operand pairs on a valid/ready request channel and launches each pair into the engine with a one-cycle go pulse. It waits for done, captures the result and returns it on a valid/ready response channel. It bypasses zero operands, which would otherwise never terminate, and bounds every wait with a timeout.

## Interface
- WIDTH, 32, operand/result width; matches the GCD engine.
- TIMEOUT, 65535, maximum WAIT cycles before abort; must be below 2^CW.
- CW, 16, width of the cycle counter and rsp_cycles.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  operand pair offered.
- req_ready  output  1  client can accept a pair; high only in IDLE.
- req_a, req_b  input  WIDTH  operands.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_gcd  output  WIDTH  result; 0 on timeout.
- rsp_timeout  output  1  result aborted by timeout.
- rsp_cycles  output  CW  WAIT cycles spent on this operation; 0 for bypass.
- gcd_go  output  1  start pulse to the engine.
- gcd_in1, gcd_in2  output  WIDTH  engine operands.
- gcd_done  input  1  engine finished; gcd_out is valid while high.
- gcd_out  input  WIDTH  engine result.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register req_a/req_b into gcd_in1/gcd_in2.
  - If both operands are nonzero, go to LAUNCH.
  - If either operand is 0, go to RESP with rsp_gcd = a|b. This gives gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0. Set rsp_cycles=0 and rsp_timeout=0.
- LAUNCH:
  - gcd_go=1 for exactly this cycle.
  - Clear the cycle counter.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle, so the first WAIT cycle counts 1.
  - If gcd_done=1: capture gcd_out into rsp_gcd and the counter into rsp_cycles, set rsp_timeout=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: set rsp_gcd=0, rsp_timeout=1, rsp_cycles=TIMEOUT, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1; rsp_* are held stable.
  - On rsp_ready, go to IDLE.
- gcd_in1/gcd_in2 stay stable from LAUNCH until the next accepted request. The engine may read them at any time.
- Engine contract: done is low in the cycle after go is sampled. A stale done from the previous operation therefore cannot be mistaken for completion in WAIT.
- After a timeout the engine is not reset by this block. The next request is launched normally; engine recovery is the system's job.

## Timing
- Reset (asynchronous assert) values:
  - state=IDLE.
  - req_ready=1 once reset deasserts.
  - rsp_valid=0, rsp_gcd=0, rsp_timeout=0, rsp_cycles=0.
  - gcd_go=0, gcd_in1=0, gcd_in2=0, busy=0.
- Reset mid-operation aborts immediately. gcd_go drops combinationally with reset, and no response is produced.
- Normal path, request accepted at edge t:
  - LAUNCH in cycle t+1.
  - WAIT from t+2.
  - If done is first high in WAIT cycle k, rsp_valid rises at the edge after that cycle, and rsp_cycles=k.
- Bypass path: rsp_valid is high in the cycle after acceptance.
- Throughput: after the RESP handshake, req_ready is high again in the next cycle. There is no overlap between operations; at most one is outstanding.
- rsp_valid is never withdrawn without rsp_ready.

## Structure
- Package gcd_pkg holds:
  - The state encoding localparams: IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3.
  - The default WIDTH, shared with the GCD engine.
- One sub-module, gcd_wait_counter: a CW-bit counter with clear, enable and a terminal flag at TIMEOUT.
- The FSM and the capture registers live in gcd_client.

## Test plan
- Req (48,18) against the real GCD engine → one gcd_go pulse, in1=48 and in2=18 during the pulse; rsp_gcd=6, rsp_timeout=0, rsp_cycles equals the cycles from go to done.
- Req (0,35), then (35,0), then (0,0) → no gcd_go; rsp_gcd=35, 35, 0 respectively; rsp_cycles=0; each rsp_valid one cycle after acceptance.
- Engine model whose done is stuck low, TIMEOUT=20 → rsp_valid after 20 WAIT cycles, rsp_gcd=0, rsp_timeout=1, rsp_cycles=20. The next request (9,6) returns 3.
- Hold rsp_ready low for 10 cycles on result 7 → rsp_valid and rsp_gcd=7 stable throughout, req_ready=0, and req_valid is ignored. On the handshake, req_ready is high in the next cycle.
- Engine model asserts done in the very cycle the counter hits TIMEOUT with gcd_out=5 → rsp_gcd=5, rsp_timeout=0.
- Assert reset during WAIT → gcd_go=0, busy=0, rsp_valid=0 immediately, with no response. After release, req (100,75) yields 25.

Source files
------------

// File: rtl/gcd_pkg.sv
// ============================================================================
// Module      : gcd_pkg
// Description : Shared state encoding and default width for the GCD client.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t LAUNCH = 2'd1;
    localparam state_t WAIT   = 2'd2;
    localparam state_t RESP   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/gcd_wait_counter.sv
// ============================================================================
// Module      : gcd_wait_counter
// Description : WAIT-cycle counter with clear, enable and terminal flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_wait_counter
    import gcd_pkg::*;
#(
    parameter int CW      = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cycles,
    output logic          at_limit
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds completed WAIT cycles, so the current cycle's number is one more.
    assign cycles   = count_q + CW'(1);
    assign at_limit = (cycles == CW'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/gcd_client.sv
// ============================================================================
// Module      : gcd_client
// Description : Request/response sequencer that drives a GCD engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_client
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 65535,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_timeout,
    output logic [CW-1:0]    rsp_cycles,
    output logic             gcd_go,
    output logic [WIDTH-1:0] gcd_in1,
    output logic [WIDTH-1:0] gcd_in2,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_out,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]    rsp_cycles_q, rsp_cycles_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CW-1:0]    cnt_cycles;
    logic             cnt_at_limit;
    logic             bypass;

    // A zero operand would never terminate in the engine; answer a|b directly.
    assign bypass = (req_a == '0) || (req_b == '0);

    gcd_wait_counter #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cycles   (cnt_cycles),
        .at_limit (cnt_at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = bypass ? RESP : LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (gcd_done || cnt_at_limit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && rst;
        rsp_valid = (state_q == RESP);
        gcd_go    = (state_q == LAUNCH);
        busy      = (state_q != IDLE);
        cnt_clr   = (state_q == LAUNCH);
        cnt_en    = (state_q == WAIT);
    end

    always_comb begin
        in1_d         = in1_q;
        in2_d         = in2_q;
        rsp_gcd_d     = rsp_gcd_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_cycles_d  = rsp_cycles_q;
        if ((state_q == IDLE) && req_valid) begin
            in1_d = req_a;
            in2_d = req_b;
            if (bypass) begin
                rsp_gcd_d     = req_a | req_b;
                rsp_timeout_d = 1'b0;
                rsp_cycles_d  = '0;
            end
        end else if (state_q == WAIT) begin
            // done takes priority over a coincident timeout
            if (gcd_done) begin
                rsp_gcd_d     = gcd_out;
                rsp_timeout_d = 1'b0;
                rsp_cycles_d  = cnt_cycles;
            end else if (cnt_at_limit) begin
                rsp_gcd_d     = '0;
                rsp_timeout_d = 1'b1;
                rsp_cycles_d  = CW'(TIMEOUT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_q         <= '0;
            in2_q         <= '0;
            rsp_gcd_q     <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= '0;
        end else begin
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            rsp_gcd_q     <= rsp_gcd_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_cycles_q  <= rsp_cycles_d;
        end
    end

    assign gcd_in1     = in1_q;
    assign gcd_in2     = in2_q;
    assign rsp_gcd     = rsp_gcd_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_cycles  = rsp_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_client.sv
// ============================================================================
// Module      : tb_gcd_client
// Description : Randomized self-checking bench for gcd_client with an engine model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_client;

    localparam int TO        = 20;
    localparam int M_NORMAL  = 0;
    localparam int M_STUCK   = 1;
    localparam int M_FIXED   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_gcd;
    logic        rsp_timeout;
    logic [15:0] rsp_cycles;
    logic        gcd_go;
    logic [31:0] gcd_in1;
    logic [31:0] gcd_in2;
    logic        gcd_done = 1'b0;
    logic [31:0] gcd_out = '0;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          eng_mode = M_NORMAL;
    int          eng_lat  = 2;
    logic [31:0] eng_fix  = '0;
    int          eng_rem  = 0;
    logic [31:0] eng_val  = '0;

    int          go_total = 0;
    logic [31:0] go_in1   = '0;
    logic [31:0] go_in2   = '0;

    gcd_client #(
        .WIDTH   (32),
        .TIMEOUT (TO),
        .CW      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_gcd     (rsp_gcd),
        .rsp_timeout (rsp_timeout),
        .rsp_cycles  (rsp_cycles),
        .gcd_go      (gcd_go),
        .gcd_in1     (gcd_in1),
        .gcd_in2     (gcd_in2),
        .gcd_done    (gcd_done),
        .gcd_out     (gcd_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: done drops after go and first rises in WAIT cycle eng_lat; it
    // then stays high (stale) until the next go.
    always @(posedge clk) begin
        if (gcd_go) begin
            gcd_done <= 1'b0;
            eng_rem  <= (eng_mode == M_STUCK) ? 0 : eng_lat - 1;
            eng_val  <= (eng_mode == M_FIXED) ? eng_fix : ref_gcd(gcd_in1, gcd_in2);
        end else if (eng_rem != 0) begin
            eng_rem <= eng_rem - 1;
            if (eng_rem == 1) begin
                gcd_done <= 1'b1;
                gcd_out  <= eng_val;
            end
        end
    end

    always @(negedge clk) begin
        if (gcd_go) begin
            go_total <= go_total + 1;
            go_in1   <= gcd_in1;
            go_in2   <= gcd_in2;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input int mode,
                           input int lat, input logic [31:0] fix, input int hold);
        logic [31:0] exp_g;
        int          exp_c, exp_n, exp_go, go0, n;
        logic        exp_to, seen;
        if (a == 0 || b == 0) begin
            exp_g = ref_gcd(a, b); exp_c = 0; exp_to = 1'b0; exp_n = 1; exp_go = 0;
        end else if (mode == M_STUCK || lat > TO) begin
            exp_g = 0; exp_c = TO; exp_to = 1'b1; exp_n = TO + 2; exp_go = 1;
        end else begin
            exp_g  = (mode == M_FIXED) ? fix : ref_gcd(a, b);
            exp_c  = lat; exp_to = 1'b0; exp_n = lat + 2; exp_go = 1;
        end

        @(negedge clk);
        eng_mode = mode;
        eng_lat  = lat;
        eng_fix  = fix;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        go0       = go_total;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;

        n    = 1;
        seen = rsp_valid;
        while (!seen && n < TO + 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            seen = rsp_valid;
        end
        check("rsp_valid_seen", seen, 1);
        check("rsp_latency", n, exp_n);
        check("rsp_gcd", rsp_gcd, exp_g);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_cycles", rsp_cycles, exp_c);
        check("go_pulses", go_total - go0, exp_go);
        check("gcd_in1_held", gcd_in1, a);
        check("gcd_in2_held", gcd_in2, b);
        if (exp_go == 1) begin
            check("go_in1", go_in1, a);
            check("go_in2", go_in2, b);
        end

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = 32'd99;
            req_b     = 32'd33;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_gcd", rsp_gcd, exp_g);
            check("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        if (hold > 0) begin
            check("hold_in1_kept", gcd_in1, a);
            check("hold_go_none", go_total - go0, exp_go);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_req_ready", req_ready, 1);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [31:0] a, b, f;
        int          go0;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_gcd", rsp_gcd, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_cycles", rsp_cycles, 0);
        check("rst_gcd_go", gcd_go, 0);
        check("rst_gcd_in1", gcd_in1, 0);
        check("rst_gcd_in2", gcd_in2, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1);

        run_req(32'd48, 32'd18, M_NORMAL, 7, '0, 0);
        run_req(32'd0, 32'd35, M_NORMAL, 5, '0, 0);
        run_req(32'd35, 32'd0, M_NORMAL, 5, '0, 0);
        run_req(32'd0, 32'd0, M_NORMAL, 5, '0, 0);
        run_req(32'd40, 32'd24, M_STUCK, 0, '0, 0);
        run_req(32'd9, 32'd6, M_NORMAL, 3, '0, 0);
        run_req(32'd14, 32'd21, M_NORMAL, 4, '0, 10);
        run_req(32'd8, 32'd12, M_FIXED, TO, 32'd5, 0);
        run_req(32'd8, 32'd12, M_NORMAL, 2, '0, 0);

        // Reset while the engine is stuck in WAIT.
        @(negedge clk);
        eng_mode  = M_STUCK;
        go0       = go_total;
        req_valid = 1'b1;
        req_a     = 32'd40;
        req_b     = 32'd30;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_go_once", go_total - go0, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_go", gcd_go, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", rsp_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (TO + 3) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        run_req(32'd100, 32'd75, M_NORMAL, 6, '0, 0);

        for (int i = 0; i < 16; i++) begin
            f = $urandom_range(1, 12);
            a = ($urandom_range(0, 5) == 0) ? 32'd0 : f * $urandom_range(1, 500);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : f * $urandom_range(1, 500);
            run_req(a, b, M_NORMAL, $urandom_range(2, TO + 2), '0, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
